mmio_bus_decoder: RTL

MMIO_BUS_DECODER -- requirements
Module: mmio_bus_decoder

---
 rtl/mmio_map_pkg.sv | 32 +++
 rtl/mmio_addr_decode.sv | 26 ++
 rtl/mmio_bus_decoder.sv | 143 ++++++++++++++
 3 files changed

// File: rtl/mmio_map_pkg.sv
// Address map, slave indices, error data and FSM state type for the MMIO decoder.
package mmio_map_pkg;

   localparam int unsigned SEL_W = 2;

   localparam logic [31:0] SRAM_BASE = 32'h0000_0000;
   localparam logic [31:0] SRAM_SIZE = 32'h0001_0000;
   localparam logic [31:0] LED_BASE  = 32'h1000_0000;
   localparam logic [31:0] LED_SIZE  = 32'h0000_0001;
   localparam logic [31:0] UART_BASE = 32'h1000_0004;
   localparam logic [31:0] UART_SIZE = 32'h0000_0004;

   localparam logic [SEL_W-1:0] SLV_SRAM = 2'd0;
   localparam logic [SEL_W-1:0] SLV_LED  = 2'd1;
   localparam logic [SEL_W-1:0] SLV_UART = 2'd2;

   localparam logic [31:0] ERR_DATA = 32'hDEAD_BEEF;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_ACCESS = 2'd1,
      ST_RESP   = 2'd2
   } state_t;

   // True when addr falls inside [base, base+size).
   function automatic logic in_range(input logic [31:0] addr,
                                     input logic [31:0] base,
                                     input logic [31:0] size);
      return (addr >= base) && ((addr - base) < size);
   endfunction

endpackage

// File: rtl/mmio_addr_decode.sv
// Combinational address decoder: maps a byte address to a slave index.
module mmio_addr_decode
   import mmio_map_pkg::*;
(
   input  logic [31:0]      addr,
   output logic             hit_c,
   output logic [SEL_W-1:0] sel_c
);

   // Priority-free decode; regions are disjoint, anything else is a miss.
   always_comb begin
      hit_c = 1'b0;
      sel_c = SLV_SRAM;
      if (in_range(addr, SRAM_BASE, SRAM_SIZE)) begin
         hit_c = 1'b1;
         sel_c = SLV_SRAM;
      end else if (in_range(addr, LED_BASE, LED_SIZE)) begin
         hit_c = 1'b1;
         sel_c = SLV_LED;
      end else if (in_range(addr, UART_BASE, UART_SIZE)) begin
         hit_c = 1'b1;
         sel_c = SLV_UART;
      end
   end

endmodule

// File: rtl/mmio_bus_decoder.sv
// CPU-to-slave MMIO bridge: decodes, forwards one access at a time, handles misses and timeouts.
module mmio_bus_decoder
   import mmio_map_pkg::*;
#(
   parameter int unsigned NUM_SLAVES     = 3,
   parameter int unsigned TIMEOUT_CYCLES = 255
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     cpu_valid,
   input  logic [31:0]              cpu_addr,
   input  logic [31:0]              cpu_wdata,
   input  logic [3:0]               cpu_wstrb,
   output logic [31:0]              cpu_rdata,
   output logic                     cpu_ready,
   output logic                     cpu_err,
   output logic [NUM_SLAVES-1:0]    s_valid,
   output logic [31:0]              s_addr,
   output logic [31:0]              s_wdata,
   output logic [3:0]               s_wstrb,
   input  logic [NUM_SLAVES*32-1:0] s_rdata,
   input  logic [NUM_SLAVES-1:0]    s_ready,
   output logic [31:0]              err_addr
);

   localparam int unsigned CNT_W = 16;

   state_t             r_state;
   state_t             w_state_next;
   logic [SEL_W-1:0]   r_sel;
   logic [SEL_W-1:0]   w_sel_next;
   logic [CNT_W-1:0]   r_cnt;
   logic               w_hit;
   logic [SEL_W-1:0]   w_dec_sel;
   logic               w_sel_ready;
   logic [31:0]        w_sel_rdata;
   logic               w_timeout;
   logic               w_resp_err;
   logic [31:0]        w_resp_data;
   logic [31:0]        w_req_addr;

   mmio_addr_decode u_decode (
      .addr  (cpu_addr),
      .hit_c (w_hit),
      .sel_c (w_dec_sel)
   );

   // Pick the ready bit and read-data slice of the selected slave only.
   always_comb begin
      w_sel_ready = 1'b0;
      w_sel_rdata = '0;
      for (int i = 0; i < int'(NUM_SLAVES); i++) begin
         if (r_sel == SEL_W'(i)) begin
            w_sel_ready = s_ready[i];
            w_sel_rdata = s_rdata[32*i +: 32];
         end
      end
   end

   assign w_timeout  = (r_cnt + CNT_W'(1)) == CNT_W'(TIMEOUT_CYCLES);
   assign w_req_addr = (r_state == ST_IDLE) ? cpu_addr : s_addr;

   // Next-state and response selection; slave ready wins over a coincident timeout.
   always_comb begin
      w_state_next = r_state;
      w_sel_next   = r_sel;
      w_resp_err   = 1'b0;
      w_resp_data  = '0;
      case (r_state)
         ST_IDLE: begin
            if (cpu_valid) begin
               w_sel_next = w_dec_sel;
               if (w_hit) begin
                  w_state_next = ST_ACCESS;
               end else begin
                  w_state_next = ST_RESP;
                  w_resp_err   = 1'b1;
                  w_resp_data  = ERR_DATA;
               end
            end
         end
         ST_ACCESS: begin
            if (w_sel_ready) begin
               w_state_next = ST_RESP;
               w_resp_data  = (s_wstrb == 4'd0) ? w_sel_rdata : 32'd0;
            end else if (w_timeout) begin
               w_state_next = ST_RESP;
               w_resp_err   = 1'b1;
               w_resp_data  = ERR_DATA;
            end
         end
         ST_RESP: begin
            w_state_next = ST_IDLE;
         end
         default: begin
            w_state_next = ST_IDLE;
         end
      endcase
   end

   // State register.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state <= ST_IDLE;
      end else begin
         r_state <= w_state_next;
      end
   end

   // Registered outputs, request latch, slave select and access timer.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_sel     <= '0;
         r_cnt     <= '0;
         s_valid   <= '0;
         s_addr    <= '0;
         s_wdata   <= '0;
         s_wstrb   <= '0;
         cpu_ready <= 1'b0;
         cpu_err   <= 1'b0;
         cpu_rdata <= '0;
         err_addr  <= '0;
      end else begin
         r_sel     <= w_sel_next;
         r_cnt     <= (r_state == ST_ACCESS) ? r_cnt + CNT_W'(1) : '0;
         s_valid   <= (w_state_next == ST_ACCESS) ? (NUM_SLAVES'(1) << w_sel_next) : '0;
         cpu_ready <= (w_state_next == ST_RESP);
         cpu_err   <= (w_state_next == ST_RESP) && w_resp_err;
         if (r_state == ST_IDLE && cpu_valid) begin
            s_addr  <= cpu_addr;
            s_wdata <= cpu_wdata;
            s_wstrb <= cpu_wstrb;
         end
         if (w_state_next == ST_RESP && r_state != ST_RESP) begin
            cpu_rdata <= w_resp_data;
            if (w_resp_err) begin
               err_addr <= w_req_addr;
            end
         end
      end
   end

endmodule
